// File: rtl/div_unit_pkg.sv
// Shared encodings and helpers for the sequential divider.
// The funct3[1:0] operation code and the FSM state type live here.
package div_unit_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_FIXUP,
    S_DONE
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] trial;
  logic            fits;

  // The compare is XLEN+1 wide; when it holds, the true difference is below the
  // divisor, so the XLEN-bit modular subtract is exact.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign fits    = (shifted >= {1'b0, divisor_i});
  assign trial   = shifted[XLEN-1:0] - divisor_i;

  assign rem_o = fits ? trial : shifted[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Sequential restoring divider (DIV/DIVU/REM/REMU and RV64 W forms), one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to send divide-by-zero and overflow straight from IDLE to FIXUP.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic            is_word_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            ready
);

  localparam int CW = $clog2(XLEN);

  // Extend from bit 31 (sign or zero); a no-op when XLEN is 32.
  function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v, input logic sx);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = WORD_W; i < XLEN; i++) r[i] = sx & v[WORD_W-1];
    return r;
  endfunction

  div_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  div_op_e         op_q;
  logic            word_q, neg_a_q, neg_b_q, dbz_q, ovf_q;
  logic [XLEN-1:0] dividend_q, divisor_q;

  // Request conditioning, valid only in the accept cycle.
  div_op_e         req_op;
  logic            word_op, signed_op, neg_a, neg_b, is_dbz, is_ovf, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg, quo_init;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    req_op    = div_op_e'(div_op);
    word_op   = (XLEN == 64) && is_word_op;
    signed_op = op_is_signed(req_op);
    a_ext     = word_op ? ext_word(operand_a, signed_op) : operand_a;
    b_ext     = word_op ? ext_word(operand_b, signed_op) : operand_b;
    neg_a     = signed_op & a_ext[XLEN-1];
    neg_b     = signed_op & b_ext[XLEN-1];
    mag_a     = neg_a ? -a_ext : a_ext;
    mag_b     = neg_b ? -b_ext : b_ext;
    min_neg   = '0;
    if (word_op) begin
      min_neg[WORD_W-1] = 1'b1;
      min_neg           = ext_word(min_neg, 1'b1);
    end else begin
      min_neg[XLEN-1] = 1'b1;
    end
    is_dbz   = (b_ext == '0);
    is_ovf   = signed_op && (a_ext == min_neg) && (b_ext == '1);
    // W dividends sit in the top half so 32 iterations consume exactly their bits.
    quo_init = word_op ? (mag_a << (XLEN - WORD_W)) : mag_a;
    accept   = (state_q == S_IDLE) && start;
  end

  logic [XLEN-1:0] step_rem, step_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  logic [CW-1:0]   last_count;
  logic [XLEN-1:0] quo_sel, rem_sel, raw_sel, fix_value;

  always_comb begin
    last_count = word_q ? CW'(WORD_W - 1) : CW'(XLEN - 1);
    quo_sel    = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    rem_sel    = neg_a_q ? -rem_q : rem_q;
    if (dbz_q) begin
      quo_sel = '1;
      rem_sel = dividend_q;
    end else if (ovf_q) begin
      quo_sel = dividend_q;
      rem_sel = '0;
    end
    raw_sel   = op_is_rem(op_q) ? rem_sel : quo_sel;
    fix_value = word_q ? ext_word(raw_sel, 1'b1) : raw_sel;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = quo_init;
          count_d = '0;
`ifdef DIV_FAST_SPECIAL_EN
          state_d = (is_dbz || is_ovf) ? S_FIXUP : S_COMPUTE;
`else
          state_d = S_COMPUTE;
`endif
        end
      end
      S_COMPUTE: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        if (count_q == last_count) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = fix_value;
        ready_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_DIV;
      word_q     <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (accept) begin
      op_q       <= req_op;
      word_q     <= word_op;
      neg_a_q    <= neg_a;
      neg_b_q    <= neg_b;
      dbz_q      <= is_dbz;
      ovf_q      <= is_ovf;
      dividend_q <= a_ext;
      divisor_q  <= mag_b;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a 32-bit and a 64-bit instance share clock and reset.
// Expected results and latencies are hand-computed constants.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int LAT_32 = 33;
  localparam int LAT_64 = 65;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, word32, busy32, ready32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        start64, word64, busy64, ready64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start32), .div_op(op32), .is_word_op(word32),
    .operand_a(a32), .operand_b(b32), .result(res32), .busy(busy32), .ready(ready32)
  );

  div_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .div_op(op64), .is_word_op(word64),
    .operand_a(a64), .operand_b(b64), .result(res64), .busy(busy64), .ready(ready64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, count edges from the accept edge until ready, then check the
  // result, latency, single-cycle ready and busy span.
  task automatic run_op(input bit w64, input div_op_e op, input bit word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int exp_lat, input bit hold, input string tag);
    int   lat;
    int   busy_cyc;
    logic rdy;
    logic bsy;
    @(negedge clk);
    if (w64) begin
      start64 = 1'b1; op64 = op; word64 = word; a64 = a; b64 = b;
    end else begin
      start32 = 1'b1; op32 = op; word32 = word; a32 = a[31:0]; b32 = b[31:0];
    end
    @(posedge clk); #1;
    start32 = hold & ~w64;
    start64 = hold & w64;
    a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D;
    a64 = 64'hDEAD_BEEF_CAFE_F00D; b64 = 64'h0123_4567_89AB_CDEF;
    lat = 0;
    busy_cyc = 0;
    rdy = w64 ? ready64 : ready32;
    bsy = w64 ? busy64 : busy32;
    if (bsy) busy_cyc++;
    while (!rdy && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      rdy = w64 ? ready64 : ready32;
      bsy = w64 ? busy64 : busy32;
      if (bsy) busy_cyc++;
    end
    check({tag, " result"}, w64 ? res64 : {32'b0, res32}, exp);
    check({tag, " ready latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    start32 = 1'b0;
    start64 = 1'b0;
    check({tag, " ready one cycle"}, 64'(w64 ? ready64 : ready32), 64'(0));
    check({tag, " busy released"}, 64'(w64 ? busy64 : busy32), 64'(0));
    check({tag, " busy cycles"}, 64'(busy_cyc), 64'(exp_lat + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1;
    start32 = 1'b0; op32 = 2'b00; word32 = 1'b0; a32 = '0; b32 = '0;
    start64 = 1'b0; op64 = 2'b00; word64 = 1'b0; a64 = '0; b64 = '0;
    #12;
    check("reset result32", {32'b0, res32}, 64'h0);
    check("reset ready32", 64'(ready32), 64'h0);
    check("reset busy32", 64'(busy32), 64'h0);
    check("reset result64", res64, 64'h0);
    check("reset busy64", 64'(busy64), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(0, OP_DIV,  0, 64'd20,        64'hFFFF_FFFD, 64'hFFFF_FFFA, LAT_32, 0, "DIV 20/-3");
    run_op(0, OP_DIV,  1, 64'd20,        64'hFFFF_FFFD, 64'hFFFF_FFFA, LAT_32, 0, "DIV 20/-3 word ignored");
    run_op(0, OP_REM,  0, 64'hFFFF_FFEC, 64'd3,         64'hFFFF_FFFE, LAT_32, 0, "REM -20/3");
    run_op(0, OP_REMU, 0, 64'hFFFF_FFEC, 64'd3,         64'h0000_0002, LAT_32, 0, "REMU 0xFFFFFFEC/3");
    run_op(0, OP_REM,  0, 64'hFFFF_FF9C, 64'd7,         64'hFFFF_FFFE, LAT_32, 0, "REM -100/7");
    run_op(0, OP_DIVU, 0, 64'd7,         64'd0,         64'hFFFF_FFFF, LAT_SPECIAL, 0, "DIVU 7/0");
    run_op(0, OP_REM,  0, 64'd7,         64'd0,         64'h0000_0007, LAT_SPECIAL, 0, "REM 7/0");
    run_op(0, OP_DIV,  0, 64'hFFFF_FFF9, 64'd0,         64'hFFFF_FFFF, LAT_SPECIAL, 0, "DIV -7/0");
    run_op(0, OP_REM,  0, 64'hFFFF_FFF9, 64'd0,         64'hFFFF_FFF9, LAT_SPECIAL, 0, "REM -7/0");
    run_op(0, OP_DIV,  0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, LAT_SPECIAL, 0, "DIV overflow");
    run_op(0, OP_REM,  0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000, LAT_SPECIAL, 0, "REM overflow");
    run_op(0, OP_DIVU, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000, LAT_32, 0, "DIVU no overflow");
    run_op(0, OP_DIVU, 0, 64'hFFFF_FFFF, 64'd1,         64'hFFFF_FFFF, LAT_32, 0, "DIVU max/1");

    // Reset in COMPUTE cycle 10 abandons the op at once, with no later ready.
    @(negedge clk);
    start32 = 1'b1; op32 = OP_DIVU; word32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid-op reset busy", 64'(busy32), 64'h0);
    check("mid-op reset ready", 64'(ready32), 64'h0);
    check("mid-op reset result", {32'b0, res32}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready32 || busy32) seen = 1'b1;
    end
    check("no activity after reset", 64'(seen), 64'h0);

    run_op(0, OP_DIVU, 0, 64'd100, 64'd7, 64'd14, LAT_32, 1, "DIVU 100/7 start held");

    run_op(1, OP_DIVU, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0, "DIVUW");
    run_op(1, OP_DIV,  1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0, "DIVW 0x80000000/1");
    run_op(1, OP_DIV,  0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, LAT_64, 0, "DIV64 100/-7");
    run_op(1, OP_REM,  1, 64'd17,  64'h0000_0000_FFFF_FFFB, 64'h0000_0000_0000_0002, 33, 0, "REMW 17/-5");
    run_op(1, OP_DIV,  1, 64'd17,  64'h0000_0000_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, "DIVW 17/-5");
    run_op(1, OP_REMU, 1, 64'h1234_5678_FFFF_FFF0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, LAT_SPECIAL, 0, "REMUW by zero");
    run_op(1, OP_DIV,  1, 64'hABCD_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, LAT_SPECIAL, 0, "DIVW overflow");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
